// File: rtl/dds_phase_gen.sv
// dds_phase_gen: phase accumulator and waveform shaper feeding the amplitude
// multiplier. The tuning word arrives over a 1-bit serial port, MSB first,
// into a pending register and is committed to the active word on ser_latch.
// One shaped unsigned sample is registered every cycle; sample_valid marks
// the cycles whose sample followed an accumulator advance.
//
// Build option: define DDS_PHASE_DITHER_EN to add a 12-bit LFSR phase dither
// ahead of the shaper. The dither affects only the shaped phase and is never
// written back into the accumulator.
module dds_phase_gen #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             phase_rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             ser_latch,
    input  logic [1:0]       wave_sel,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic             wrap
);

    // Number of accumulator LSBs dropped when forming the shaper phase.
    localparam int unsigned PHASE_SHIFT = ACC_W - OUT_W;

    typedef enum logic [1:0] {
        WAVE_SAW  = 2'b00,
        WAVE_TRI  = 2'b01,
        WAVE_SQR  = 2'b10,
        WAVE_ISAW = 2'b11
    } wave_e;

    // The phase slice needs at least one accumulator bit below it.
    if (ACC_W < OUT_W + 1) begin : g_width_check
        $error("dds_phase_gen: ACC_W must be at least OUT_W+1");
    end

    logic [ACC_W-1:0] fw_pend;
    logic [ACC_W-1:0] fw_active;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [OUT_W-1:0] phase;
    logic [OUT_W-1:0] ramp2x;
    logic [OUT_W-1:0] shaped;

    // Serial tuning-word load; a latch in the same cycle as a shift commits
    // the pre-shift pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            fw_pend   <= '0;
            fw_active <= '0;
        end else begin
            if (ser_valid) begin
                fw_pend <= {fw_pend[ACC_W-2:0], ser_in};
            end
            if (ser_latch) begin
                fw_active <= fw_pend;
            end
        end
    end

    // Carry-extended add; the MSB is the overflow that drives wrap.
    assign acc_sum = {1'b0, acc} + {1'b0, fw_active};

    // Phase accumulator with phase_rst taking priority over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (phase_rst) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            acc  <= acc_sum[ACC_W-1:0];
            wrap <= acc_sum[ACC_W];
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef DDS_PHASE_DITHER_EN
    localparam int unsigned LFSR_W = 12;

    // Dither must sit entirely below the phase slice.
    if (PHASE_SHIFT < LFSR_W) begin : g_dither_check
        $error("dds_phase_gen: dither needs ACC_W-OUT_W >= 12");
    end

    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_fb;
    logic [ACC_W-1:0]  dith_sum;

    // Fibonacci feedback from taps 12,11,10,4.
    assign lfsr_fb = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];

    // LFSR advances once per enabled cycle, seeded non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_W'(1);
        end else if (en) begin
            lfsr <= {lfsr[LFSR_W-2:0], lfsr_fb};
        end
    end

    assign dith_sum = acc + ACC_W'(lfsr);
    assign phase    = OUT_W'(dith_sum >> PHASE_SHIFT);
`else
    assign phase    = OUT_W'(acc >> PHASE_SHIFT);
`endif

    // Doubled ramp used for both halves of the triangle.
    assign ramp2x = {phase[OUT_W-2:0], 1'b0};

    // Waveform shaper on the pre-add phase.
    always_comb begin
        shaped = '0;
        case (wave_e'(wave_sel))
            WAVE_SAW:  shaped = phase;
            WAVE_TRI:  shaped = phase[OUT_W-1] ? ~ramp2x : ramp2x;
            WAVE_SQR:  shaped = {OUT_W{phase[OUT_W-1]}};
            WAVE_ISAW: shaped = ~phase;
            default:   shaped = '0;
        endcase
    end

    // Output registers; the sample updates every cycle, valid only after en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_out   <= shaped;
            sample_valid <= en & ~phase_rst;
        end
    end

endmodule
